// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 encodings and lane helpers shared by the load/store unit
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } access_size_e;

  function automatic access_size_e size_of(input logic [2:0] f3);
    access_size_e sz;
    case (f3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic load_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (size_of(f3))
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (size_of(f3))
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicating across lanes lets the memory pick any lane with the mask alone.
  function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (size_of(f3))
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// rtl/load_store_unit_load_align.sv - selects the addressed byte/half of a memory word and extends it
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {24'h000000, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store sequencer between the core MEMORY stage and data RAM
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [31:0]           load_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [3:0]            mem_byte_mask,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [31:0]           store_data_q;
  logic                  is_load_q;
  logic                  is_store_q;
  logic                  fault_q;
  logic [31:0]           load_data_q;
  logic [31:0]           aligned_data;
  logic                  accept;
  logic                  req_fault;
  logic                  unused_addr_hi;

  // Byte-address bits above the memory size wrap and are deliberately dropped.
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  assign accept = start && (state_q == S_IDLE);

  always_comb begin
    req_fault = 1'b0;
    if (is_load) begin
      req_fault = !load_legal(funct3) || misaligned(funct3, addr[1:0]);
    end else if (is_store) begin
      req_fault = !store_legal(funct3) || misaligned(funct3, addr[1:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_fault || (!is_load && !is_store)) begin
            state_d = S_DONE;
          end else if (is_load) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      funct3_q     <= 3'b000;
      store_data_q <= 32'h0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      fault_q      <= 1'b0;
      load_data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q       <= addr[ADDR_WIDTH+1:0];
        funct3_q     <= funct3;
        store_data_q <= store_data;
        is_load_q    <= is_load;
        is_store_q   <= is_store;
        fault_q      <= req_fault;
      end
      if (state_q == S_CAPTURE) begin
        load_data_q <= aligned_data;
      end
    end
  end

  load_align u_load_align (
    .word      (mem_read_data),
    .offset    (addr_q[1:0]),
    .funct3    (funct3_q),
    .load_data (aligned_data)
  );

  // Outputs are masked by reset so an abandoned request cannot strobe during the reset cycle.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    fault            = 1'b0;
    mem_addr         = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_byte_mask    = 4'b0000;
    mem_write_data   = 32'h0;
    if (!reset) begin
      busy  = (state_q != S_IDLE);
      done  = (state_q == S_DONE);
      fault = (state_q == S_DONE) && fault_q;
      if (state_q == S_READ) begin
        mem_addr        = addr_q[ADDR_WIDTH+1:2];
        mem_read_enable = is_load_q;
      end
      if (state_q == S_WRITE) begin
        mem_addr         = addr_q[ADDR_WIDTH+1:2];
        mem_write_enable = is_store_q && !is_load_q;
        mem_byte_mask    = store_mask(funct3_q, addr_q[1:0]);
        mem_write_data   = store_replicate(funct3_q, store_data_q);
      end
    end
  end

  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector, random and reset-sequence checks for load_store_unit
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic [6:0]  mem_addr;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [3:0]  mem_byte_mask;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [128];

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.ADDR_WIDTH(7)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .is_load          (is_load),
    .is_store         (is_store),
    .funct3           (funct3),
    .addr             (addr),
    .store_data       (store_data),
    .busy             (busy),
    .done             (done),
    .fault            (fault),
    .load_data        (load_data),
    .mem_addr         (mem_addr),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_byte_mask    (mem_byte_mask),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: word appears one cycle after the read strobe, garbage otherwise.
  always @(posedge clock) begin
    mem_read_data <= mem_read_enable ? mem[mem_addr] : 32'h0BAD0BAD;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic m_fault(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] a);
    int size;
    size = 1 << (f3 % 4);
    if (ld) return !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) || (a % size != 0);
    if (st) return (f3 > 2) || (a % size != 0);
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [31:0] v;
    int off;
    off = a % 4;
    if (f3 == 0 || f3 == 4) begin
      v = (w >> (off * 8)) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v - 256;
    end else if (f3 == 1 || f3 == 5) begin
      v = (w >> ((off / 2) * 16)) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_mask(input logic [31:0] a, input logic [2:0] f3);
    if (f3 == 0) return 4'(1 << (a % 4));
    if (f3 == 1) return 4'(3 << (((a % 4) / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f3);
    if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  // Issues one request at a negedge and watches it to completion and return to IDLE.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic inject,
                        output int done_cyc, output int done_cnt, output int rd_cnt,
                        output int wr_cnt, output int rd_cyc, output int wr_cyc,
                        output logic fault_s, output logic [31:0] ld_s,
                        output logic [6:0] rd_addr, output logic [6:0] wr_addr,
                        output logic [3:0] wr_mask, output logic [31:0] wr_data,
                        output logic leak, output logic ld_stable);
    done_cyc = -1; done_cnt = 0; rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1;
    fault_s = 1'b0; ld_s = 32'h0; rd_addr = 7'h0; wr_addr = 7'h0; wr_mask = 4'h0;
    wr_data = 32'h0; leak = 1'b0; ld_stable = 1'b0;
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (mem_read_enable) begin rd_cnt++; rd_cyc = k; rd_addr = mem_addr; end
      if (mem_write_enable) begin
        wr_cnt++; wr_cyc = k; wr_addr = mem_addr; wr_mask = mem_byte_mask; wr_data = mem_write_data;
      end else if (mem_byte_mask != 4'h0 || mem_write_data != 32'h0) begin
        leak = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = k; fault_s = fault; ld_s = load_data; end
      end
      is_load = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; store_data = $urandom;
      start = inject && busy;
      if (done_cyc > 0 && !busy) begin
        ld_stable = (load_data === ld_s);
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic inject,
                       input logic exp_fault, input int exp_lat, input logic [31:0] exp_ld,
                       input logic [6:0] exp_maddr, input logic [3:0] exp_mask,
                       input logic [31:0] exp_wdata);
    int done_cyc, done_cnt, rd_cnt, wr_cnt, rd_cyc, wr_cyc;
    logic fault_s, leak, ld_stable;
    logic [31:0] ld_s, wr_data;
    logic [6:0] rd_addr, wr_addr;
    logic [3:0] wr_mask;
    logic ld_path, st_path;
    ld_path = ld && !exp_fault;
    st_path = !ld && st && !exp_fault;
    run_op(ld, st, f3, a, d, inject, done_cyc, done_cnt, rd_cnt, wr_cnt, rd_cyc, wr_cyc,
           fault_s, ld_s, rd_addr, wr_addr, wr_mask, wr_data, leak, ld_stable);
    chk({tag, " done_cycle"}, done_cyc, exp_lat);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " fault"}, {31'h0, fault_s}, {31'h0, exp_fault});
    chk({tag, " load_data"}, ld_s, exp_ld);
    chk({tag, " read_strobes"}, rd_cnt, {31'h0, ld_path});
    chk({tag, " write_strobes"}, wr_cnt, {31'h0, st_path});
    chk({tag, " idle_lane_leak"}, {31'h0, leak}, 32'h0);
    chk({tag, " load_data_held"}, {31'h0, ld_stable}, 32'h1);
    if (ld_path) begin
      chk({tag, " read_cycle"}, rd_cyc, 1);
      chk({tag, " read_addr"}, {25'h0, rd_addr}, {25'h0, exp_maddr});
    end
    if (st_path) begin
      chk({tag, " write_cycle"}, wr_cyc, 1);
      chk({tag, " write_addr"}, {25'h0, wr_addr}, {25'h0, exp_maddr});
      chk({tag, " write_mask"}, {28'h0, wr_mask}, {28'h0, exp_mask});
      chk({tag, " write_data"}, wr_data, exp_wdata);
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] word;
    logic        exp_fault;
    int          exp_lat;
    logic [31:0] exp_ld;
    logic [6:0]  exp_maddr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [13];

  task automatic check_idle_outputs(input string tag);
    chk({tag, " busy"}, {31'h0, busy}, 32'h0);
    chk({tag, " done"}, {31'h0, done}, 32'h0);
    chk({tag, " fault"}, {31'h0, fault}, 32'h0);
    chk({tag, " rd_en"}, {31'h0, mem_read_enable}, 32'h0);
    chk({tag, " wr_en"}, {31'h0, mem_write_enable}, 32'h0);
    chk({tag, " mask"}, {28'h0, mem_byte_mask}, 32'h0);
    chk({tag, " wdata"}, mem_write_data, 32'h0);
  endtask

  initial begin
    logic [31:0] prev_ld;
    logic        ld, st, flt;
    logic [2:0]  f3;
    logic [31:0] a, d, w;
    int          lat;
    int          done_seen;

    vecs[0]  = '{1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 7'd4,  4'h0, 32'h0};
    vecs[1]  = '{1, 0, 3'b000, 32'h13,  32'h0,        32'h80FF7F01, 0, 3, 32'hFFFFFF80, 7'd4,  4'h0, 32'h0};
    vecs[2]  = '{1, 0, 3'b100, 32'h13,  32'h0,        32'h80FF7F01, 0, 3, 32'h00000080, 7'd4,  4'h0, 32'h0};
    vecs[3]  = '{0, 1, 3'b001, 32'h22,  32'h1234ABCD, 32'h0,        0, 2, 32'h00000080, 7'd8,  4'hC, 32'hABCDABCD};
    vecs[4]  = '{1, 0, 3'b010, 32'h21,  32'h0,        32'h0,        1, 1, 32'h00000080, 7'd8,  4'h0, 32'h0};
    vecs[5]  = '{1, 0, 3'b001, 32'h12,  32'h0,        32'h80FF7F01, 0, 3, 32'hFFFF80FF, 7'd4,  4'h0, 32'h0};
    vecs[6]  = '{1, 0, 3'b101, 32'h10,  32'h0,        32'h80FF7F01, 0, 3, 32'h00007F01, 7'd4,  4'h0, 32'h0};
    vecs[7]  = '{0, 1, 3'b000, 32'h203, 32'hAA55,     32'h0,        0, 2, 32'h00007F01, 7'd0,  4'h8, 32'h55555555};
    vecs[8]  = '{0, 1, 3'b010, 32'h7C,  32'hCAFEF00D, 32'h0,        0, 2, 32'h00007F01, 7'd31, 4'hF, 32'hCAFEF00D};
    vecs[9]  = '{0, 0, 3'b010, 32'h10,  32'h0,        32'h0,        0, 1, 32'h00007F01, 7'd0,  4'h0, 32'h0};
    vecs[10] = '{1, 0, 3'b011, 32'h0,   32'h0,        32'h0,        1, 1, 32'h00007F01, 7'd0,  4'h0, 32'h0};
    vecs[11] = '{0, 1, 3'b100, 32'h0,   32'h0,        32'h0,        1, 1, 32'h00007F01, 7'd0,  4'h0, 32'h0};
    vecs[12] = '{1, 1, 3'b010, 32'h10,  32'h77,       32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 7'd4,  4'h0, 32'h0};

    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("reset_state");
    chk("reset_state load_data", load_data, 32'h0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].ld && !vecs[i].exp_fault) mem[vecs[i].exp_maddr] = vecs[i].word;
      do_op($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].d,
            1'(i % 2), vecs[i].exp_fault, vecs[i].exp_lat, vecs[i].exp_ld, vecs[i].exp_maddr,
            vecs[i].exp_mask, vecs[i].exp_wdata);
    end

    prev_ld = 32'hDEADBEEF;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       begin ld = 0; st = 0; end
        1:       begin ld = 1; st = 0; end
        2:       begin ld = 0; st = 1; end
        default: begin ld = 1; st = 1; end
      endcase
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3 % 4 == 1) a[0] = 1'b0;
        if (f3 % 4 == 2) a[1:0] = 2'b00;
      end
      flt = m_fault(ld, st, f3, a);
      lat = (flt || (!ld && !st)) ? 1 : (ld ? 3 : 2);
      w = mem[(a >> 2) % 128];
      if (ld && !flt) prev_ld = m_load(w, a, f3);
      do_op($sformatf("rand%0d", i), ld, st, f3, a, d, 1'($urandom), flt, lat, prev_ld,
            7'((a >> 2) % 128), m_mask(a, f3), m_wdata(d, f3));
    end

    // Reset while in CAPTURE abandons the load.
    mem[4] = 32'h13579BDF;
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_capture done_in_reset", {31'h0, done}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_capture after");
    chk("rst_capture load_data", load_data, 32'h0);
    done_seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (done || busy || mem_read_enable) done_seen++;
    end
    chk("rst_capture quiet", done_seen, 0);

    // Reset asserted during WRITE must suppress the strobe in that same cycle.
    start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h40;
    store_data = 32'h11223344;
    @(negedge clock);
    start = 1'b0;
    chk("rst_write strobe_before", {31'h0, mem_write_enable}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_write strobe_in_reset", {31'h0, mem_write_enable}, 32'h0);
    chk("rst_write mask_in_reset", {28'h0, mem_byte_mask}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy || mem_write_enable) done_seen++;
    end
    chk("rst_write quiet", done_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
